k4red_sched: RTL and testbench

Round-robin scheduler and configuration controller for the shared 5-stage K^4-RED modular-reduction datapath (`k4red_s`). It accepts 64-bit operands from NREQ requesters, issues at most one per cycle into the datapath, and tracks each in-flight operation with a valid/ID/tag pipe. It returns each 32-bit result to its originator. Configuration (Q, k1..k4, m) is not pipelined inside the datapath, so the block drains all in-flight work before it applies a new configuration.

---
 rtl/k4red_sched.sv | 201 ++++++++++++++++++++
 tb/tb_k4red_sched.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k4red_sched.sv
// k4red_sched: round-robin issue scheduler and configuration controller for
// the shared K^4-RED reduction datapath. Requests are issued one per cycle,
// tracked through a valid/id/tag pipe that matches the datapath latency, and
// returned to their originator. A new configuration is applied only after
// all in-flight work has drained.
//
// Optional feature: define K4RED_SCHED_RANGE_CHECK_EN to reject out-of-range
// configurations (cfg_err pulses with cfg_ready, previous config is kept).
module k4red_sched #(
  parameter int NREQ = 4,
  parameter int TAGW = 4,
  parameter int LAT  = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*64-1:0]         req_a,
  input  logic [NREQ*TAGW-1:0]       req_tag,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  output logic                       cfg_err,
  input  logic [31:0]                cfg_q,
  input  logic [5:0]                 cfg_k1,
  input  logic [5:0]                 cfg_k2,
  input  logic [5:0]                 cfg_k3,
  input  logic [5:0]                 cfg_k4,
  input  logic [5:0]                 cfg_m,
  output logic [63:0]                dp_a,
  output logic [31:0]                dp_q,
  output logic [5:0]                 dp_k1,
  output logic [5:0]                 dp_k2,
  output logic [5:0]                 dp_k3,
  output logic [5:0]                 dp_k4,
  output logic [5:0]                 dp_m,
  input  logic [31:0]                dp_c2,
  output logic                       rsp_valid,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [TAGW-1:0]            rsp_tag,
  output logic [31:0]                rsp_c2
);

  localparam int IDW = $clog2(NREQ);

  localparam logic [1:0] S_UNCFG = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_LOAD  = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [IDW-1:0]           last_grant_q;
  logic [63:0]              dp_a_q;
  logic [31:0]              dp_q_q;
  logic [5:0]               dp_k1_q, dp_k2_q, dp_k3_q, dp_k4_q, dp_m_q;
  logic [LAT:0]             vld_q;
  logic [LAT:0][IDW-1:0]    id_q;
  logic [LAT:0][TAGW-1:0]   tag_q;

  logic                     grant_found;
  logic [IDW-1:0]           grant_idx;
  logic [IDW-1:0]           cand;
  logic                     xfer;
  logic [63:0]              grant_a;
  logic [TAGW-1:0]          grant_tag;
  logic                     cfg_accept;
  logic                     cfg_seen;

`ifdef K4RED_SCHED_RANGE_CHECK_EN
  logic                     cfg_seen_q;

  // Range check of the requested configuration (k + m < 31 is k < 31 - m).
  always_comb begin
    cfg_accept = (cfg_m >= 6'd1) && (cfg_m <= 6'd30) && (cfg_q != 32'd0) &&
                 (({1'b0, cfg_k1} + {1'b0, cfg_m}) < 7'd31) &&
                 (({1'b0, cfg_k2} + {1'b0, cfg_m}) < 7'd31) &&
                 (({1'b0, cfg_k3} + {1'b0, cfg_m}) < 7'd31) &&
                 (({1'b0, cfg_k4} + {1'b0, cfg_m}) < 7'd31);
  end

  // Remember whether any configuration has ever been accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_seen_q <= 1'b0;
    end else if (state_q == S_LOAD && cfg_accept) begin
      cfg_seen_q <= 1'b1;
    end
  end

  assign cfg_seen = cfg_seen_q;
  assign cfg_err  = (state_q == S_LOAD) && !cfg_accept;
`else
  assign cfg_accept = 1'b1;
  assign cfg_seen   = 1'b1;
  assign cfg_err    = 1'b0;
`endif

  // Round-robin search: first valid requester after last_grant, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = IDW'((int'(last_grant_q) + off) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // A pending configuration request blocks new grants in RUN.
  assign xfer      = (state_q == S_RUN) && !cfg_valid && grant_found;
  assign req_ready = xfer ? (NREQ'(1) << grant_idx) : '0;

  // Select the granted requester's operand and tag.
  always_comb begin
    grant_a   = '0;
    grant_tag = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        grant_a   = req_a[64*i +: 64];
        grant_tag = req_tag[TAGW*i +: TAGW];
      end
    end
  end

  // Next-state logic for the configuration FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_UNCFG: if (cfg_valid) state_d = S_LOAD;
      S_RUN:   if (cfg_valid) state_d = S_DRAIN;
      S_DRAIN: if (vld_q == '0) state_d = S_LOAD;
      S_LOAD:  state_d = (cfg_accept || cfg_seen) ? S_RUN : S_UNCFG;
      default: state_d = S_UNCFG;
    endcase
  end

  // FSM state and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_UNCFG;
      last_grant_q <= IDW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      if (xfer) begin
        last_grant_q <= grant_idx;
      end
    end
  end

  // Operand register and tracking pipe; stage LAT lines up with dp_c2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_a_q <= '0;
      vld_q  <= '0;
      id_q   <= '0;
      tag_q  <= '0;
    end else begin
      dp_a_q <= xfer ? grant_a : 64'd0;
      vld_q  <= {vld_q[LAT-1:0], xfer};
      id_q   <= {id_q[LAT-1:0], (xfer ? grant_idx : {IDW{1'b0}})};
      tag_q  <= {tag_q[LAT-1:0], grant_tag};
    end
  end

  // Active configuration; only updated in LOAD, when the pipe is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_q_q  <= '0;
      dp_k1_q <= '0;
      dp_k2_q <= '0;
      dp_k3_q <= '0;
      dp_k4_q <= '0;
      dp_m_q  <= '0;
    end else if (state_q == S_LOAD && cfg_accept) begin
      dp_q_q  <= cfg_q;
      dp_k1_q <= cfg_k1;
      dp_k2_q <= cfg_k2;
      dp_k3_q <= cfg_k3;
      dp_k4_q <= cfg_k4;
      dp_m_q  <= cfg_m;
    end
  end

  assign cfg_ready = (state_q == S_LOAD);

  assign dp_a  = dp_a_q;
  assign dp_q  = dp_q_q;
  assign dp_k1 = dp_k1_q;
  assign dp_k2 = dp_k2_q;
  assign dp_k3 = dp_k3_q;
  assign dp_k4 = dp_k4_q;
  assign dp_m  = dp_m_q;

  assign rsp_valid = vld_q[LAT];
  assign rsp_id    = id_q[LAT];
  assign rsp_tag   = tag_q[LAT];
  assign rsp_c2    = vld_q[LAT] ? dp_c2 : 32'd0;

endmodule

// File: tb/tb_k4red_sched.sv
// Testbench for k4red_sched with a LAT-edge datapath stub (returns dp_a[31:0]).
// Honours K4RED_SCHED_RANGE_CHECK_EN when computing the m=31 expectation.
`timescale 1ns/1ps
module tb_k4red_sched;
  localparam int NREQ = 4;
  localparam int TAGW = 4;
  localparam int LAT  = 5;
  localparam int IDW  = $clog2(NREQ);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*64-1:0]   req_a;
  logic [NREQ*TAGW-1:0] req_tag;
  logic                 cfg_valid, cfg_ready, cfg_err;
  logic [31:0]          cfg_q;
  logic [5:0]           cfg_k1, cfg_k2, cfg_k3, cfg_k4, cfg_m;
  logic [63:0]          dp_a;
  logic [31:0]          dp_q;
  logic [5:0]           dp_k1, dp_k2, dp_k3, dp_k4, dp_m;
  logic [31:0]          dp_c2;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [TAGW-1:0]      rsp_tag;
  logic [31:0]          rsp_c2;

  logic [63:0]          op_a [NREQ];
  logic [TAGW-1:0]      op_t [NREQ];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_a[64*g +: 64]     = op_a[g];
    assign req_tag[TAGW*g +: TAGW] = op_t[g];
  end

  k4red_sched #(.NREQ(NREQ), .TAGW(TAGW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_tag(req_tag),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .cfg_q(cfg_q), .cfg_k1(cfg_k1), .cfg_k2(cfg_k2), .cfg_k3(cfg_k3), .cfg_k4(cfg_k4), .cfg_m(cfg_m),
    .dp_a(dp_a), .dp_q(dp_q), .dp_k1(dp_k1), .dp_k2(dp_k2), .dp_k3(dp_k3), .dp_k4(dp_k4), .dp_m(dp_m),
    .dp_c2(dp_c2),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_c2(rsp_c2)
  );

  // Datapath stub: LAT-edge delay line of dp_a[31:0].
  logic [31:0] stub_q [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) stub_q[i] <= '0;
    end else begin
      stub_q[0] <= dp_a[31:0];
      for (int i = 1; i < LAT; i++) stub_q[i] <= stub_q[i-1];
    end
  end
  assign dp_c2 = stub_q[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard of expected responses, keyed by the cycle they must appear.
  typedef struct {
    int              due;
    logic [IDW-1:0]  id;
    logic [TAGW-1:0] tag;
    logic [31:0]     c2;
  } exp_t;
  exp_t sb[$];

  initial begin : monitor
    logic [63:0] exp_dpa;
    exp_t e;
    exp_dpa = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        exp_dpa = '0;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      end else begin
        chk("dp_a", dp_a, exp_dpa);
        if (sb.size() > 0 && sb[0].due == cyc) begin
          chk("rsp_valid", 64'(rsp_valid), 64'd1);
          chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
          chk("rsp_tag", 64'(rsp_tag), 64'(sb[0].tag));
          chk("rsp_c2", 64'(rsp_c2), 64'(sb[0].c2));
          void'(sb.pop_front());
        end else begin
          chk("rsp_idle", 64'(rsp_valid), 64'd0);
        end
        exp_dpa = '0;
        if (req_ready != '0) begin
          chk("ready_onehot", 64'($onehot(req_ready)), 64'd1);
          chk("ready_subset", 64'(req_ready & ~req_valid), 64'd0);
          for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
              exp_dpa = op_a[i];
              e.due = cyc + 1 + LAT;
              e.id  = IDW'(i);
              e.tag = op_t[i];
              e.c2  = op_a[i][31:0];
              sb.push_back(e);
            end
          end
        end
      end
    end
  end

  // Reference state: round-robin pointer, last issue cycle, active config.
  int          model_last;
  int          last_xfer;
  logic [31:0] cur_q;
  logic [5:0]  cur_k1, cur_k2, cur_k3, cur_k4, cur_m;

  task automatic randomize_ops(input bit tag_is_id);
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = {$urandom, $urandom};
      op_t[i] = tag_is_id ? TAGW'(i) : TAGW'($urandom);
    end
  endtask

  // One RUN cycle with no configuration request: grant predicted by round-robin.
  task automatic cycle_req(input logic [NREQ-1:0] v, input bit tag_is_id);
    logic [NREQ-1:0] exp;
    int gi, idx;
    @(posedge clk); #1;
    req_valid = v;
    randomize_ops(tag_is_id);
    exp = '0;
    gi  = -1;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (model_last + off) % NREQ;
      if (gi < 0 && v[idx]) gi = idx;
    end
    if (gi >= 0) exp[gi] = 1'b1;
    @(negedge clk);
    chk("arb_ready", 64'(req_ready), 64'(exp));
    if (gi >= 0) begin
      model_last = gi;
      last_xfer  = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
    end
  endtask

  // Configuration request; expected wait derived from the last issue cycle.
  task automatic do_cfg(input logic [31:0] q_, input logic [5:0] k1, input logic [5:0] k2,
                        input logic [5:0] k3, input logic [5:0] k4, input logic [5:0] m,
                        input bit from_uncfg, input logic exp_err);
    int c0, n, exp_n, d;
    @(posedge clk); #1;
    cfg_valid = 1'b1;
    cfg_q = q_; cfg_k1 = k1; cfg_k2 = k2; cfg_k3 = k3; cfg_k4 = k4; cfg_m = m;
    c0 = cyc;
    d  = (c0 + 1 > last_xfer + 2 + LAT) ? c0 + 1 : last_xfer + 2 + LAT;
    exp_n = from_uncfg ? 1 : d + 1 - c0;
    n = 0;
    @(negedge clk);
    while (!cfg_ready && n < 64) begin
      chk("wait_ready", 64'(req_ready), 64'd0);
      chk("wait_dp_m", 64'(dp_m), 64'(cur_m));
      chk("wait_dp_q", 64'(dp_q), 64'(cur_q));
      @(negedge clk);
      n++;
    end
    chk("cfg_wait", 64'(cyc - c0), 64'(exp_n));
    chk("cfg_err", 64'(cfg_err), 64'(exp_err));
    chk("load_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    req_valid = '0;
    if (!exp_err) begin
      cur_q = q_; cur_k1 = k1; cur_k2 = k2; cur_k3 = k3; cur_k4 = k4; cur_m = m;
    end
    chk("dp_q", 64'(dp_q), 64'(cur_q));
    chk("dp_k", 64'({dp_k1, dp_k2, dp_k3, dp_k4}), 64'({cur_k1, cur_k2, cur_k3, cur_k4}));
    chk("dp_m", 64'(dp_m), 64'(cur_m));
    @(negedge clk);
    chk("cfg_pulse", 64'(cfg_ready), 64'd0);
  endtask

  typedef struct {
    logic [NREQ-1:0] rv;
    logic [NREQ-1:0] exp;
  } arb_vec_t;
  arb_vec_t tbl [12];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int c, n;
    logic [5:0] rm, rk1, rk2, rk3, rk4;
    logic exp31;

    tbl[0]  = '{rv: 4'b1111, exp: 4'b0001};
    tbl[1]  = '{rv: 4'b1111, exp: 4'b0010};
    tbl[2]  = '{rv: 4'b0001, exp: 4'b0001};
    tbl[3]  = '{rv: 4'b1001, exp: 4'b1000};
    tbl[4]  = '{rv: 4'b0000, exp: 4'b0000};
    tbl[5]  = '{rv: 4'b0110, exp: 4'b0010};
    tbl[6]  = '{rv: 4'b0011, exp: 4'b0001};
    tbl[7]  = '{rv: 4'b0001, exp: 4'b0001};
    tbl[8]  = '{rv: 4'b1100, exp: 4'b0100};
    tbl[9]  = '{rv: 4'b0100, exp: 4'b0100};
    tbl[10] = '{rv: 4'b1010, exp: 4'b1000};
    tbl[11] = '{rv: 4'b1010, exp: 4'b0010};

    rst = 1'b1;
    req_valid = '0;
    cfg_valid = 1'b0;
    cfg_q = '0; cfg_k1 = '0; cfg_k2 = '0; cfg_k3 = '0; cfg_k4 = '0; cfg_m = '0;
    for (int i = 0; i < NREQ; i++) begin op_a[i] = '0; op_t[i] = '0; end
    model_last = NREQ - 1;
    last_xfer  = -100;
    cur_q = '0; cur_k1 = '0; cur_k2 = '0; cur_k3 = '0; cur_k4 = '0; cur_m = '0;

    // Reset values
    #2 req_valid = '1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_rsp", 64'({rsp_valid, rsp_id, rsp_tag}), 64'd0);
    chk("rst_dp_a", dp_a, 64'd0);
    chk("rst_dp_cfg", 64'({dp_q, dp_k1, dp_k2, dp_k3, dp_k4, dp_m}), 64'd0);
    req_valid = '0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // Unconfigured: no grants
    repeat (3) begin
      @(posedge clk); #1 req_valid = '1;
      @(negedge clk);
      chk("uncfg_ready", 64'(req_ready), 64'd0);
    end
    do_cfg(32'h0000_3001, 6'd1, 6'd2, 6'd3, 6'd4, 6'd10, 1'b1, 1'b0);

    // Arbitration table
    for (int r = 0; r < 12; r++) begin
      @(posedge clk); #1;
      req_valid = tbl[r].rv;
      for (int i = 0; i < NREQ; i++) begin
        op_a[i] = 64'hA5A5_0000_0000_0000 | 64'(r * 16 + i);
        op_t[i] = TAGW'(r + i);
      end
      @(negedge clk);
      chk("tbl_ready", 64'(req_ready), 64'(tbl[r].exp));
      for (int i = 0; i < NREQ; i++) begin
        if (tbl[r].exp[i]) begin
          model_last = i;
          last_xfer  = cyc;
        end
      end
    end
    idle(LAT + 3);

    // Single operation latency: requester 0, A=0x1234, tag 3
    @(posedge clk); #1;
    req_valid = 4'b0001;
    op_a[0] = 64'h1234;
    op_t[0] = 4'd3;
    @(negedge clk);
    chk("single_ready", 64'(req_ready), 64'd1);
    model_last = 0;
    last_xfer  = cyc;
    c = cyc;
    n = 0;
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("single_latency", 64'(cyc), 64'(c + 1 + LAT));
    chk("single_id", 64'(rsp_id), 64'd0);
    chk("single_tag", 64'(rsp_tag), 64'd3);
    chk("single_c2", 64'(rsp_c2), 64'h1234);
    idle(LAT + 2);

    // All requesters continuously valid, tags equal to IDs
    repeat (12) cycle_req(4'b1111, 1'b1);
    idle(LAT + 3);

    // Three in flight, then reconfigure to m=12 (drain before load)
    repeat (3) cycle_req(4'b1111, 1'b0);
    do_cfg(32'h0000_3001, 6'd1, 6'd2, 6'd3, 6'd4, 6'd12, 1'b0, 1'b0);
    idle(LAT + 3);

    // m=31 from RUN with an empty pipe
`ifdef K4RED_SCHED_RANGE_CHECK_EN
    exp31 = 1'b1;
`else
    exp31 = 1'b0;
`endif
    do_cfg(32'h0000_3001, 6'd0, 6'd0, 6'd0, 6'd0, 6'd31, 1'b0, exp31);

    // Randomized traffic with occasional valid reconfiguration
    for (int it = 0; it < 300; it++) begin
      if (it % 75 == 74) begin
        rm  = 6'($urandom_range(1, 20));
        rk1 = 6'($urandom_range(0, 30 - int'(rm)));
        rk2 = 6'($urandom_range(0, 30 - int'(rm)));
        rk3 = 6'($urandom_range(0, 30 - int'(rm)));
        rk4 = 6'($urandom_range(0, 30 - int'(rm)));
        do_cfg($urandom | 32'd1, rk1, rk2, rk3, rk4, rm, 1'b0, 1'b0);
      end else begin
        cycle_req(NREQ'($urandom), 1'b0);
      end
    end

    // Asynchronous reset mid-clock with 4 operations in flight
    repeat (4) cycle_req(4'b1111, 1'b0);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("arst_req_ready", 64'(req_ready), 64'd0);
    chk("arst_rsp", 64'({rsp_valid, rsp_id, rsp_tag}), 64'd0);
    chk("arst_rsp_c2", 64'(rsp_c2), 64'd0);
    chk("arst_cfg", 64'({cfg_ready, cfg_err}), 64'd0);
    chk("arst_dp_a", dp_a, 64'd0);
    chk("arst_dp_cfg", 64'({dp_q, dp_k1, dp_k2, dp_k3, dp_k4, dp_m}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    model_last = NREQ - 1;
    last_xfer  = -100;
    cur_q = '0; cur_k1 = '0; cur_k2 = '0; cur_k3 = '0; cur_k4 = '0; cur_m = '0;
    repeat (10) begin
      @(posedge clk); #1 req_valid = '1;
      @(negedge clk);
      chk("post_rst_ready", 64'(req_ready), 64'd0);
    end
    do_cfg(32'h0000_3001, 6'd1, 6'd2, 6'd3, 6'd4, 6'd10, 1'b1, 1'b0);
    repeat (6) cycle_req(4'b1111, 1'b0);
    idle(LAT + 4);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
